cross_bar_nxm: RTL



---
 rtl/cross_bar_nxm_pkg.sv | 36 +++
 rtl/cross_bar_nxm_if.sv | 50 +++++
 rtl/cross_bar_nxm_slave_port.sv | 130 +++++++++++++
 rtl/cross_bar_nxm.sv | 104 ++++++++++
 4 files changed

// File: rtl/cross_bar_nxm_pkg.sv
// -----------------------------------------------------------------------------
// cross_bar_nxm_pkg
// Shared definitions for the N x M crossbar: default sizing constants, the
// per-slave-port FSM state encoding and the address-to-slave decode helper.
// -----------------------------------------------------------------------------
package cross_bar_nxm_pkg;

  localparam int unsigned DEF_N_MASTERS  = 4;
  localparam int unsigned DEF_N_SLAVES   = 4;
  localparam int unsigned DEF_ADDR_WIDTH = 32;
  localparam int unsigned DEF_DATA_WIDTH = 32;

  // Widest address the decode helper accepts; narrower addresses are
  // zero-extended by the caller.
  localparam int unsigned MAX_ADDR_WIDTH = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // arbitrating among eligible masters
    ST_ADDR = 2'd1,  // request presented to the slave, waiting for s_ack
    ST_RESP = 2'd2   // read accepted, waiting for s_resp
  } port_state_e;

  // Slave index = the top log2(n_slaves) bits of an addr_width-bit address.
  function automatic int unsigned slave_index(
    input logic [MAX_ADDR_WIDTH-1:0] addr,
    input int unsigned               addr_width,
    input int unsigned               n_slaves
  );
    int unsigned               sel_bits;
    logic [MAX_ADDR_WIDTH-1:0] shifted;
    sel_bits = $clog2(n_slaves);
    shifted  = addr >> (addr_width - sel_bits);
    return 32'(shifted & MAX_ADDR_WIDTH'(n_slaves - 1));
  endfunction

endpackage

// File: rtl/cross_bar_nxm_if.sv
// -----------------------------------------------------------------------------
// cross_bar_nxm_if
// Bundles every master-side and slave-side bus signal of the crossbar.
//   m_req/m_addr/m_cmd/m_wdata : requests from masters (cmd 0 = read, 1 = write)
//   m_ack/m_resp/m_rdata       : accept strobe, read-data valid, read data
//   s_req/s_addr/s_cmd/s_wdata : requests forwarded to slaves
//   s_ack/s_resp/s_rdata       : slave accept strobe, read-response strobe, data
// Modports: xbar (the crossbar), master (requesters), slave (targets).
// -----------------------------------------------------------------------------
interface cross_bar_nxm_if
  import cross_bar_nxm_pkg::*;
#(
  parameter int unsigned N_MASTERS  = DEF_N_MASTERS,
  parameter int unsigned N_SLAVES   = DEF_N_SLAVES,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
);

  logic [N_MASTERS-1:0]                 m_req;
  logic [N_MASTERS-1:0][ADDR_WIDTH-1:0] m_addr;
  logic [N_MASTERS-1:0]                 m_cmd;
  logic [N_MASTERS-1:0][DATA_WIDTH-1:0] m_wdata;
  logic [N_MASTERS-1:0]                 m_ack;
  logic [N_MASTERS-1:0]                 m_resp;
  logic [N_MASTERS-1:0][DATA_WIDTH-1:0] m_rdata;

  logic [N_SLAVES-1:0]                  s_req;
  logic [N_SLAVES-1:0][ADDR_WIDTH-1:0]  s_addr;
  logic [N_SLAVES-1:0]                  s_cmd;
  logic [N_SLAVES-1:0][DATA_WIDTH-1:0]  s_wdata;
  logic [N_SLAVES-1:0]                  s_ack;
  logic [N_SLAVES-1:0]                  s_resp;
  logic [N_SLAVES-1:0][DATA_WIDTH-1:0]  s_rdata;

  modport xbar (
    input  m_req, m_addr, m_cmd, m_wdata, s_ack, s_resp, s_rdata,
    output m_ack, m_resp, m_rdata, s_req, s_addr, s_cmd, s_wdata
  );

  modport master (
    output m_req, m_addr, m_cmd, m_wdata,
    input  m_ack, m_resp, m_rdata
  );

  modport slave (
    input  s_req, s_addr, s_cmd, s_wdata,
    output s_ack, s_resp, s_rdata
  );

endinterface

// File: rtl/cross_bar_nxm_slave_port.sv
// -----------------------------------------------------------------------------
// xbar_slave_port
// One slave port of the crossbar: round-robin arbiter, owner register and the
// IDLE/ADDR/RESP transfer FSM.
//   elig                   : masters allowed to win this port this cycle
//   m_req/m_addr/m_cmd/m_wdata : full master request buses (owner is muxed out)
//   s_*                    : this port's slave-side signals
//   m_ack/m_resp/m_rdata   : per-master returns, non-zero only at the owner
//   rd_set/rd_clr          : one-hot strobes that set/clear the owner's
//                            read-pending flag held in the top level
// -----------------------------------------------------------------------------
module xbar_slave_port
  import cross_bar_nxm_pkg::*;
#(
  parameter int unsigned N_MASTERS  = DEF_N_MASTERS,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  localparam int unsigned IDX_W     = $clog2(N_MASTERS)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [N_MASTERS-1:0]                 elig,
  input  logic [N_MASTERS-1:0]                 m_req,
  input  logic [N_MASTERS-1:0][ADDR_WIDTH-1:0] m_addr,
  input  logic [N_MASTERS-1:0]                 m_cmd,
  input  logic [N_MASTERS-1:0][DATA_WIDTH-1:0] m_wdata,
  output logic                                 s_req,
  output logic [ADDR_WIDTH-1:0]                s_addr,
  output logic                                 s_cmd,
  output logic [DATA_WIDTH-1:0]                s_wdata,
  input  logic                                 s_ack,
  input  logic                                 s_resp,
  input  logic [DATA_WIDTH-1:0]                s_rdata,
  output logic [N_MASTERS-1:0]                 m_ack,
  output logic [N_MASTERS-1:0]                 m_resp,
  output logic [N_MASTERS-1:0][DATA_WIDTH-1:0] m_rdata,
  output logic [N_MASTERS-1:0]                 rd_set,
  output logic [N_MASTERS-1:0]                 rd_clr
);

  port_state_e      state, state_nx;
  logic [IDX_W-1:0] owner, owner_nx;
  logic [IDX_W-1:0] ptr, ptr_nx;
  logic             grant_any;
  logic [IDX_W-1:0] grant_idx;

  // First eligible master at or after the pointer, wrapping at N_MASTERS.
  always_comb begin : arbiter
    int unsigned cand;
    cand      = 0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int unsigned k = 0; k < N_MASTERS; k++) begin
      cand = (32'(ptr) + k) % N_MASTERS;
      if (!grant_any && elig[IDX_W'(cand)]) begin
        grant_any = 1'b1;
        grant_idx = IDX_W'(cand);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      owner <= '0;
      ptr   <= '0;
    end else begin
      state <= state_nx;
      owner <= owner_nx;
      ptr   <= ptr_nx;
    end
  end

  // NOTE: every output of this block is assigned a default first, so no path
  // through the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    owner_nx = owner;
    ptr_nx   = ptr;
    s_req    = 1'b0;
    s_addr   = '0;
    s_cmd    = 1'b0;
    s_wdata  = '0;
    m_ack    = '0;
    m_resp   = '0;
    m_rdata  = '0;
    rd_set   = '0;
    rd_clr   = '0;
    unique case (state)
      ST_IDLE: begin
        if (grant_any) begin
          owner_nx = grant_idx;
          ptr_nx   = (grant_idx == IDX_W'(N_MASTERS - 1)) ? '0 : grant_idx + 1'b1;
          state_nx = ST_ADDR;
        end
      end
      ST_ADDR: begin
        s_req   = 1'b1;
        s_addr  = m_addr[owner];
        s_cmd   = m_cmd[owner];
        s_wdata = m_wdata[owner];
        // A withdrawn request wins over a same-cycle s_ack: the master
        // never sees an ack for a request it has already abandoned.
        if (!m_req[owner]) begin
          state_nx = ST_IDLE;
        end else if (s_ack) begin
          m_ack[owner] = 1'b1;
          if (m_cmd[owner]) begin
            state_nx = ST_IDLE;
          end else begin
            rd_set[owner] = 1'b1;
            state_nx      = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        m_resp[owner]  = s_resp;
        m_rdata[owner] = s_rdata;
        if (s_resp) begin
          rd_clr[owner] = 1'b1;
          state_nx      = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/cross_bar_nxm.sv
// -----------------------------------------------------------------------------
// cross_bar_nxm
// N_MASTERS x N_SLAVES request/response crossbar. Each slave port arbitrates
// independently (round robin); a master with a read outstanding on any slave
// cannot win any port until that read's response returns.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : all master- and slave-side signals (cross_bar_nxm_if.xbar)
// -----------------------------------------------------------------------------
module cross_bar_nxm
  import cross_bar_nxm_pkg::*;
#(
  parameter int unsigned N_MASTERS  = DEF_N_MASTERS,
  parameter int unsigned N_SLAVES   = DEF_N_SLAVES,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  cross_bar_nxm_if.xbar bus
);

  localparam int unsigned SEL_W = $clog2(N_SLAVES);

  logic [N_MASTERS-1:0][SEL_W-1:0]                     sel;
  logic [N_MASTERS-1:0]                                rd_pend;
  logic [N_MASTERS-1:0]                                rd_set_any, rd_clr_any;
  logic [N_SLAVES-1:0][N_MASTERS-1:0]                  elig;
  logic [N_SLAVES-1:0][N_MASTERS-1:0]                  ack_v, resp_v, set_v, clr_v;
  logic [N_SLAVES-1:0][N_MASTERS-1:0][DATA_WIDTH-1:0]  rdata_v;
  logic [N_SLAVES-1:0]                                 s_req_v, s_cmd_v;
  logic [N_SLAVES-1:0][ADDR_WIDTH-1:0]                 s_addr_v;
  logic [N_SLAVES-1:0][DATA_WIDTH-1:0]                 s_wdata_v;

  always_comb begin
    sel  = '0;
    elig = '0;
    for (int unsigned i = 0; i < N_MASTERS; i++) begin
      sel[i] = SEL_W'(slave_index(MAX_ADDR_WIDTH'(bus.m_addr[i]), ADDR_WIDTH, N_SLAVES));
    end
    for (int unsigned j = 0; j < N_SLAVES; j++) begin
      for (int unsigned i = 0; i < N_MASTERS; i++) begin
        elig[j][i] = bus.m_req[i] && !rd_pend[i] && (sel[i] == SEL_W'(j));
      end
    end
  end

  for (genvar j = 0; j < N_SLAVES; j++) begin : g_port
    xbar_slave_port #(
      .N_MASTERS  (N_MASTERS),
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_port (
      .clk     (clk),
      .rst_n   (rst_n),
      .elig    (elig[j]),
      .m_req   (bus.m_req),
      .m_addr  (bus.m_addr),
      .m_cmd   (bus.m_cmd),
      .m_wdata (bus.m_wdata),
      .s_req   (s_req_v[j]),
      .s_addr  (s_addr_v[j]),
      .s_cmd   (s_cmd_v[j]),
      .s_wdata (s_wdata_v[j]),
      .s_ack   (bus.s_ack[j]),
      .s_resp  (bus.s_resp[j]),
      .s_rdata (bus.s_rdata[j]),
      .m_ack   (ack_v[j]),
      .m_resp  (resp_v[j]),
      .m_rdata (rdata_v[j]),
      .rd_set  (set_v[j]),
      .rd_clr  (clr_v[j])
    );
  end

  assign bus.s_req   = s_req_v;
  assign bus.s_addr  = s_addr_v;
  assign bus.s_cmd   = s_cmd_v;
  assign bus.s_wdata = s_wdata_v;

  // Each port drives only its owner's lanes, so returns merge by OR.
  always_comb begin
    bus.m_ack   = '0;
    bus.m_resp  = '0;
    bus.m_rdata = '0;
    rd_set_any  = '0;
    rd_clr_any  = '0;
    for (int unsigned j = 0; j < N_SLAVES; j++) begin
      bus.m_ack   = bus.m_ack   | ack_v[j];
      bus.m_resp  = bus.m_resp  | resp_v[j];
      bus.m_rdata = bus.m_rdata | rdata_v[j];
      rd_set_any  = rd_set_any  | set_v[j];
      rd_clr_any  = rd_clr_any  | clr_v[j];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend <= '0;
    end else begin
      rd_pend <= (rd_pend & ~rd_clr_any) | rd_set_any;
    end
  end

endmodule
